note_seq: RTL and testbench

NOTE_SEQ -- requirements
Module: note_seq

---
 rtl/note_seq.sv | 193 +++++++++++++++++++
 tb/tb_note_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/note_seq.sv
// note_seq -- plays a fixed table of notes as a stream of half-period words.
//
// Each table entry is {period[15:0], dur[7:0]}. A note holds its period for
// dur ticks of TICK_DIV clocks, then GAP_TICKS silent ticks follow. A dur of
// 0 marks the end of the song. With LOOP = 1 the song restarts at entry 0.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous active-high reset
//   start   begin playback from entry 0 (honoured only when idle)
//   stop    abort playback, back to idle with no done pulse
//   period  half-period word for the tone stage, 0 = silence
//   busy    high whenever the sequencer is not idle
//   done    one-cycle pulse on normal end of song
//   index   current table entry
//
// TABLE packs entry i at bits [i*24 +: 24]. The default is a 16-entry
// melody; override TABLE together with NOTES.

module note_seq #(
  parameter int TICK_DIV  = 48000,
  parameter int NOTES     = 16,
  parameter int GAP_TICKS = 1,
  parameter int LOOP      = 0,
  parameter logic [NOTES*24-1:0] TABLE = {
    16'd0,  8'd0, 16'd91, 8'd8, 16'd81, 8'd4, 16'd72, 8'd4,
    16'd68, 8'd4, 16'd61, 8'd4, 16'd54, 8'd4, 16'd48, 8'd4,
    16'd45, 8'd8, 16'd48, 8'd4, 16'd54, 8'd4, 16'd61, 8'd4,
    16'd68, 8'd4, 16'd72, 8'd4, 16'd81, 8'd4, 16'd91, 8'd4
  }
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [15:0] period,
  output logic        busy,
  output logic        done,
  output logic [7:0]  index
);

  // Index is one bit wider than the port so it can reach NOTES = 256
  // without wrapping; reaching NOTES is treated as end of song.
  localparam int IW = 9;
  localparam int PW = $clog2(TICK_DIV);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);
  localparam logic [IW-1:0] IDX_END   = IW'(NOTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     period_q, period_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      rem_q, rem_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            tick;
  logic [23:0]     entry;
  logic            end_of_song;

  assign tick = (presc_q == PRESC_MAX);

  // Table lookup; an index at or past NOTES matches no entry and reads as
  // all-zero, i.e. an end-of-song marker.
  always_comb begin
    entry = '0;
    for (int i = 0; i < NOTES; i++) begin
      if (idx_q == IW'(i)) entry = TABLE[i*24 +: 24];
    end
  end

  assign end_of_song = (idx_q >= IDX_END) || (entry[7:0] == 8'd0);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    idx_d    = idx_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    gap_d    = gap_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end

      S_LOAD: begin
        if (end_of_song) begin
          // Looping from a non-zero index re-reads entry 0; an empty song
          // (marker at entry 0) always finishes so it can never spin.
          if (LOOP != 0 && idx_q != '0) begin
            idx_d = '0;
          end else begin
            state_d  = S_DONE;
            period_d = '0;
          end
        end else begin
          period_d = entry[23:8];
          rem_d    = entry[7:0];
          presc_d  = '0;
          state_d  = S_PLAY;
        end
      end

      S_PLAY: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            if (GAP_TICKS > 0) begin
              period_d = '0;
              gap_d    = GAP_LOAD;
              state_d  = S_GAP;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_LOAD;
            end
          end
        end
      end

      S_GAP: begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) begin
          gap_d = gap_q - 1'b1;
          if (gap_q == GW'(1)) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition above.
    if (stop && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      period_d = '0;
      idx_d    = '0;
      presc_d  = '0;
      rem_d    = '0;
      gap_d    = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      idx_q    <= '0;
      presc_q  <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
    end
  end

  assign period = period_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign index  = idx_q[7:0];

endmodule

// File: tb/tb_note_seq.sv
// Scoreboard bench for note_seq. Four instances cover the gapped song,
// legato, looping and empty-song configurations. The stimulus process pushes
// hand-computed expected output events (cycle + output values); the monitor
// pops an event whenever a DUT's outputs change or an event falls due.

module tb_note_seq;

  // entry 0 = (100,2), entry 1 = (200,1), entry 2 = end marker (period ignored)
  localparam logic [71:0] TBL3  = {16'hBEEF, 8'd0, 16'd200, 8'd1, 16'd100, 8'd2};
  // entry 0 is the end marker
  localparam logic [47:0] TBL_E = {16'd100, 8'd2, 16'd300, 8'd0};

  typedef struct packed {
    logic [63:0] tag;
    int          cyc;
    int          dut;
    logic [15:0] period;
    logic        busy;
    logic        done;
    logic [7:0]  index;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;
  logic [3:0]  rst_v, start_v, stop_v;
  logic [15:0] per_a  [4];
  logic        busy_a [4];
  logic        done_a [4];
  logic [7:0]  idx_a  [4];

  exp_t        sb[$];
  int          rd_ptr = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        flush = 1'b0;
  logic        flushed = 1'b0;
  logic [25:0] prev [4];
  logic [25:0] obs;
  exp_t        h;
  logic        have, due;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_seq #(.TICK_DIV(4), .NOTES(3), .GAP_TICKS(1), .LOOP(0), .TABLE(TBL3)) u_a (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .stop(stop_v[0]),
    .period(per_a[0]), .busy(busy_a[0]), .done(done_a[0]), .index(idx_a[0]));

  note_seq #(.TICK_DIV(4), .NOTES(3), .GAP_TICKS(0), .LOOP(0), .TABLE(TBL3)) u_b (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .stop(stop_v[1]),
    .period(per_a[1]), .busy(busy_a[1]), .done(done_a[1]), .index(idx_a[1]));

  note_seq #(.TICK_DIV(4), .NOTES(3), .GAP_TICKS(1), .LOOP(1), .TABLE(TBL3)) u_c (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .stop(stop_v[2]),
    .period(per_a[2]), .busy(busy_a[2]), .done(done_a[2]), .index(idx_a[2]));

  note_seq #(.TICK_DIV(4), .NOTES(2), .GAP_TICKS(1), .LOOP(1), .TABLE(TBL_E)) u_d (
    .clk(clk), .reset(rst_v[3]), .start(start_v[3]), .stop(stop_v[3]),
    .period(per_a[3]), .busy(busy_a[3]), .done(done_a[3]), .index(idx_a[3]));

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (cyc < 2) begin
      for (int d = 0; d < 4; d++) prev[d] = '0;
    end else if (!flushed) begin
      for (int d = 0; d < 4; d++) begin
        obs  = {per_a[d], busy_a[d], done_a[d], idx_a[d]};
        have = (rd_ptr < sb.size());
        h    = have ? sb[rd_ptr] : '0;
        due  = have && (h.dut == d) && (h.cyc == cyc);
        if (obs != prev[d] || due) begin
          vectors++;
          if (!have) begin
            miscompares++;
            $display("FAIL unexpected: dut%0d cycle %0d period=%0d busy=%0b done=%0b index=%0d, required no change",
                     d, cyc, obs[25:10], obs[9], obs[8], obs[7:0]);
          end else begin
            rd_ptr++;
            if (h.dut != d || h.cyc != cyc ||
                obs != {h.period, h.busy, h.done, h.index}) begin
              miscompares++;
              $display("FAIL %s: got dut%0d cycle %0d period=%0d busy=%0b done=%0b index=%0d, required dut%0d cycle %0d period=%0d busy=%0b done=%0b index=%0d",
                       h.tag, d, cyc, obs[25:10], obs[9], obs[8], obs[7:0],
                       h.dut, h.cyc, h.period, h.busy, h.done, h.index);
            end
          end
        end
        prev[d] = obs;
      end
      if (flush) begin
        while (rd_ptr < sb.size()) begin
          h = sb[rd_ptr];
          vectors++;
          miscompares++;
          $display("FAIL %s: event never seen, required dut%0d cycle %0d period=%0d busy=%0b done=%0b index=%0d",
                   h.tag, h.dut, h.cyc, h.period, h.busy, h.done, h.index);
          rd_ptr++;
        end
        flushed = 1'b1;
      end
    end
  end

  task automatic ev(input logic [63:0] tag, input int c, input int d,
                    input int p, input logic b, input logic dn, input int ix);
    exp_t e;
    e.tag    = tag;
    e.cyc    = c;
    e.dut    = d;
    e.period = 16'(p);
    e.busy   = b;
    e.done   = dn;
    e.index  = 8'(ix);
    sb.push_back(e);
  endtask

  // Advance until the free-running cycle counter reaches k (always bounded).
  task automatic go(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_v   = '1;
    start_v = '0;
    stop_v  = '0;

    for (int d = 0; d < 4; d++) ev("reset", 5, d, 0, 0, 0, 0);
    go(3);
    rst_v = '0;

    // Gapped song, with start pulses during PLAY that must be ignored.
    ev("a_load0", 11, 0, 0,   1, 0, 0);
    ev("a_note0", 12, 0, 100, 1, 0, 0);
    ev("a_gap0",  20, 0, 0,   1, 0, 0);
    ev("a_load1", 24, 0, 0,   1, 0, 1);
    ev("a_note1", 25, 0, 200, 1, 0, 1);
    ev("a_gap1",  29, 0, 0,   1, 0, 1);
    ev("a_load2", 33, 0, 0,   1, 0, 2);
    ev("a_done",  34, 0, 0,   1, 1, 2);
    ev("a_idle",  35, 0, 0,   0, 0, 2);
    go(10); start_v[0] = 1'b1;
    go(11); start_v[0] = 1'b0;
    go(14); start_v[0] = 1'b1;
    go(15); start_v[0] = 1'b0;
    go(26); start_v[0] = 1'b1;
    go(27); start_v[0] = 1'b0;

    // Legato: period held through the LOAD between notes.
    ev("b_load0", 51, 1, 0,   1, 0, 0);
    ev("b_note0", 52, 1, 100, 1, 0, 0);
    ev("b_load1", 60, 1, 100, 1, 0, 1);
    ev("b_note1", 61, 1, 200, 1, 0, 1);
    ev("b_load2", 65, 1, 200, 1, 0, 2);
    ev("b_done",  66, 1, 0,   1, 1, 2);
    ev("b_idle",  67, 1, 0,   0, 0, 2);
    go(50); start_v[1] = 1'b1;
    go(51); start_v[1] = 1'b0;

    // Looping song, wraps to entry 0, then aborted with stop.
    ev("c_load0", 81,  2, 0,   1, 0, 0);
    ev("c_note0", 82,  2, 100, 1, 0, 0);
    ev("c_gap0",  90,  2, 0,   1, 0, 0);
    ev("c_load1", 94,  2, 0,   1, 0, 1);
    ev("c_note1", 95,  2, 200, 1, 0, 1);
    ev("c_gap1",  99,  2, 0,   1, 0, 1);
    ev("c_load2", 103, 2, 0,   1, 0, 2);
    ev("c_wrap",  104, 2, 0,   1, 0, 0);
    ev("c_replay",105, 2, 100, 1, 0, 0);
    ev("c_stop",  108, 2, 0,   0, 0, 0);
    go(80);  start_v[2] = 1'b1;
    go(81);  start_v[2] = 1'b0;
    go(107); stop_v[2]  = 1'b1;
    go(108); stop_v[2]  = 1'b0;

    // Reset during the second tick of note 0; start while in reset is ignored.
    ev("r_load0", 121, 0, 0,   1, 0, 0);
    ev("r_note0", 122, 0, 100, 1, 0, 0);
    ev("r_reset", 128, 0, 0,   0, 0, 0);
    ev("r_stays", 133, 0, 0,   0, 0, 0);
    go(120); start_v[0] = 1'b1;
    go(121); start_v[0] = 1'b0;
    go(127); rst_v[0]   = 1'b1;
    go(128); start_v[0] = 1'b1;
    go(129); start_v[0] = 1'b0;
    go(130); rst_v[0]   = 1'b0;

    // Empty song with LOOP = 1: LOAD, DONE, IDLE.
    ev("d_load",  151, 3, 0, 1, 0, 0);
    ev("d_done",  152, 3, 0, 1, 1, 0);
    ev("d_idle",  153, 3, 0, 0, 0, 0);
    go(150); start_v[3] = 1'b1;
    go(151); start_v[3] = 1'b0;

    // stop and start together during PLAY abort to IDLE.
    ev("s_load0", 171, 1, 0,   1, 0, 0);
    ev("s_note0", 172, 1, 100, 1, 0, 0);
    ev("s_abort", 176, 1, 0,   0, 0, 0);
    ev("s_stays", 179, 1, 0,   0, 0, 0);
    go(170); start_v[1] = 1'b1;
    go(171); start_v[1] = 1'b0;
    go(175); start_v[1] = 1'b1; stop_v[1] = 1'b1;
    go(176); start_v[1] = 1'b0; stop_v[1] = 1'b0;

    // start and stop together in IDLE: stays idle.
    ev("i_both",  187, 3, 0, 0, 0, 0);
    go(185); start_v[3] = 1'b1; stop_v[3] = 1'b1;
    go(186); start_v[3] = 1'b0; stop_v[3] = 1'b0;

    go(200);
    flush = 1'b1;
    go(203);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
